// File: rtl/guess_game_ctrl.sv
// rtl/guess_game_ctrl.sv - number-guessing game controller for the seven-segment display path
//
// Synchronises and debounces the start/submit buttons, draws an 8-bit target
// from a free-running LFSR, counts attempts and drives the display fields.
//
// Ports:
//   clock_100Mhz  in   system clock, all logic on the rising edge
//   reset_n       in   asynchronous active-low reset
//   btn_start     in   raw start button (asynchronous)
//   btn_submit    in   raw submit button (asynchronous)
//   sw_guess[7:0] in   raw guess switches (asynchronous)
//   number[7:0]   out  hex value for the two numeric digits
//   sel[2:0]      out  status word: 1 = "UI" win, 2 = "LO" lose, 3 = "Ao" again/attract
//   tries_left[3:0] out remaining attempts
//   game_over     out  high while the game sits in WIN or LOSE
//
// Optional feature: define GUESS_HINT_EN to show an above/below hint digit
// (A = guess above target, B = guess below target) while the "again" result is held.

`timescale 1ns/1ps

module guess_game_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clock_100Mhz,
    input  logic reset_n,
    input  logic level_sync,
    output logic rise
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          level;
    logic          level_q;
    logic [CW-1:0] count;

    // The accepted level only flips after CYCLES consecutive disagreeing samples;
    // a single agreeing sample restarts the count.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            level   <= 1'b0;
            level_q <= 1'b0;
            count   <= '0;
        end else begin
            level_q <= level;
            if (level_sync != level) begin
                if (count == CW'(CYCLES - 1)) begin
                    level <= level_sync;
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

    assign rise = level & ~level_q;
endmodule

module guess_game_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 1_000_000,
    parameter int         HOLD_CYCLES     = 200_000_000,
    parameter int         MAX_TRIES       = 8,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       clock_100Mhz,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_submit,
    input  logic [7:0] sw_guess,
    output logic [7:0] number,
    output logic [2:0] sel,
    output logic [3:0] tries_left,
    output logic       game_over
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [2:0] SEL_WIN   = 3'd1;
    localparam logic [2:0] SEL_LOSE  = 3'd2;
    localparam logic [2:0] SEL_AGAIN = 3'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        CHECK = 3'd2,
        AGAIN = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    // Two-flop synchronisers for all asynchronous inputs
    logic       start_meta, start_sync;
    logic       submit_meta, submit_sync;
    logic [7:0] guess_meta, guess_sync;

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            start_meta  <= 1'b0;
            start_sync  <= 1'b0;
            submit_meta <= 1'b0;
            submit_sync <= 1'b0;
            guess_meta  <= 8'h00;
            guess_sync  <= 8'h00;
        end else begin
            start_meta  <= btn_start;
            start_sync  <= start_meta;
            submit_meta <= btn_submit;
            submit_sync <= submit_meta;
            guess_meta  <= sw_guess;
            guess_sync  <= guess_meta;
        end
    end

    logic start_p, submit_p;

    guess_game_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .level_sync   (start_sync),
        .rise         (start_p)
    );

    guess_game_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_submit_db (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .level_sync   (submit_sync),
        .rise         (submit_p)
    );

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; a non-zero seed keeps it off the all-zero lock-up
    logic [7:0] lfsr;

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Game state and datapath registers
    state_t        state, state_next;
    logic [3:0]    tries_next;
    logic [3:0]    tries_dec;
    logic [HW-1:0] hold_count, hold_next;
    logic [7:0]    target, target_next;
    logic [7:0]    guess, guess_next;
`ifdef GUESS_HINT_EN
    logic [3:0]    hint, hint_next;
`endif

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tries_left <= 4'(MAX_TRIES);
            hold_count <= '0;
            target     <= 8'h00;
            guess      <= 8'h00;
`ifdef GUESS_HINT_EN
            hint       <= 4'h0;
`endif
        end else begin
            state      <= state_next;
            tries_left <= tries_next;
            hold_count <= hold_next;
            target     <= target_next;
            guess      <= guess_next;
`ifdef GUESS_HINT_EN
            hint       <= hint_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        tries_next  = tries_left;
        hold_next   = hold_count;
        target_next = target;
        guess_next  = guess;
`ifdef GUESS_HINT_EN
        hint_next   = hint;
`endif
        // Saturating decrement so a misconfigured count can never wrap to 15
        tries_dec   = (tries_left != 4'd0) ? (tries_left - 4'd1) : 4'd0;

        // A start press restarts the game from any state and shadows a
        // simultaneous submit, which is simply dropped.
        if (start_p) begin
            target_next = lfsr;
            tries_next  = 4'(MAX_TRIES);
            hold_next   = '0;
            state_next  = PLAY;
        end else begin
            case (state)
                PLAY: begin
                    if (submit_p) begin
                        guess_next = guess_sync;
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    if (guess == target) begin
                        state_next = WIN;
                    end else begin
                        tries_next = tries_dec;
`ifdef GUESS_HINT_EN
                        hint_next  = (guess > target) ? 4'hA : 4'hB;
`endif
                        if (tries_dec == 4'd0) begin
                            state_next = LOSE;
                        end else begin
                            hold_next  = HW'(HOLD_CYCLES - 1);
                            state_next = AGAIN;
                        end
                    end
                end
                AGAIN: begin
                    if (hold_count == '0) begin
                        state_next = PLAY;
                    end else begin
                        hold_next = hold_count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Display fields follow the state register one cycle later; CHECK keeps
    // whatever was shown during PLAY so the digits do not flicker.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            number    <= 8'h00;
            sel       <= SEL_AGAIN;
            game_over <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    number    <= 8'h00;
                    sel       <= SEL_AGAIN;
                    game_over <= 1'b0;
                end
                PLAY: begin
                    number    <= guess_sync;
                    sel       <= SEL_AGAIN;
                    game_over <= 1'b0;
                end
                AGAIN: begin
`ifdef GUESS_HINT_EN
                    number    <= {hint, tries_left};
`else
                    number    <= {4'h0, tries_left};
`endif
                    sel       <= SEL_AGAIN;
                    game_over <= 1'b0;
                end
                WIN: begin
                    number    <= target;
                    sel       <= SEL_WIN;
                    game_over <= 1'b1;
                end
                LOSE: begin
                    number    <= target;
                    sel       <= SEL_LOSE;
                    game_over <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb/tb_guess_game_ctrl.sv - scoreboard bench for guess_game_ctrl

`timescale 1ns/1ps

module tb_guess_game_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int MAXT = 3;

    localparam int G_IDLE = 0;
    localparam int G_PLAY = 1;
    localparam int G_WIN  = 2;
    localparam int G_LOSE = 3;

    logic       clock_100Mhz = 1'b0;
    logic       reset_n      = 1'b0;
    logic       btn_start    = 1'b0;
    logic       btn_submit   = 1'b0;
    logic [7:0] sw_guess     = 8'h00;
    logic [7:0] number;
    logic [2:0] sel;
    logic [3:0] tries_left;
    logic       game_over;

    guess_game_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .MAX_TRIES       (MAXT),
        .LFSR_SEED       (8'hA5)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .btn_start    (btn_start),
        .btn_submit   (btn_submit),
        .sw_guess     (sw_guess),
        .number       (number),
        .sel          (sel),
        .tries_left   (tries_left),
        .game_over    (game_over)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    int cyc = 0;
    always @(posedge clock_100Mhz) cyc <= cyc + 1;

    // Reference random source: the polynomial stepped once per clock while out of reset
    logic [7:0] m_lfsr;
    always @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 8'hA5;
        else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
        return r;
    endfunction

    typedef struct {
        int         cyc;
        logic [7:0] num;
        logic [2:0] sel;
        logic [3:0] tries;
        logic       go;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    total = 0;
    int    bad   = 0;

    // Game-level model
    logic [7:0] m_target = 8'h00;
    int         m_tries  = MAXT;
    int         m_state  = G_IDLE;

    task automatic expect_at(input int c, input logic [7:0] n, input logic [2:0] s,
                             input logic [3:0] t, input logic g, input string tag);
        exp_t e;
        e.cyc = c; e.num = n; e.sel = s; e.tries = t; e.go = g;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic chk(input string tag, input string field, input int act, input int exp, input int c);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h at cycle %0d", tag, field, act, exp, c);
        end
    endtask

    // Monitor: compares every expectation due in the current cycle
    always @(negedge clock_100Mhz) begin : monitor
        exp_t  keep[$];
        string keep_tag[$];
        keep = {};
        keep_tag = {};
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == cyc) begin
                chk(sb_tag[i], "number",     int'(number),     int'(sb[i].num),   cyc);
                chk(sb_tag[i], "sel",        int'(sel),        int'(sb[i].sel),   cyc);
                chk(sb_tag[i], "tries_left", int'(tries_left), int'(sb[i].tries), cyc);
                chk(sb_tag[i], "game_over",  int'(game_over),  int'(sb[i].go),    cyc);
            end else if (sb[i].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: expectation for cycle %0d was never sampled", sb_tag[i], sb[i].cyc);
            end else begin
                keep.push_back(sb[i]);
                keep_tag.push_back(sb_tag[i]);
            end
        end
        sb = keep;
        sb_tag = keep_tag;
    end

    // Raw press at negedge k: synchronised by edge k+2, accepted after DEB more
    // edges, pulse consumed at edge k+7, so the target is the LFSR after k+6 edges.
    task automatic do_start(input logic [7:0] sw);
        int k;
        k = cyc;
        sw_guess  = sw;
        btn_start = 1'b1;
        m_target  = lfsr_adv(m_lfsr, 6);
        m_tries   = MAXT;
        m_state   = G_PLAY;
        expect_at(k + 8, sw, 3'd3, 4'(MAXT), 1'b0, "start_play");
        repeat (6) @(negedge clock_100Mhz);
        btn_start = 1'b0;
        repeat (8) @(negedge clock_100Mhz);
    endtask

    task automatic do_submit(input logic [7:0] sw, input int span);
        int         k;
        int         nt;
        logic [3:0] hint;
        k = cyc;
        sw_guess   = sw;
        btn_submit = 1'b1;
        if (m_state == G_PLAY) begin
            if (sw == m_target) begin
                expect_at(k + 8, sw, 3'd3, 4'(m_tries), 1'b0, "win_pending");
                expect_at(k + 9, m_target, 3'd1, 4'(m_tries), 1'b1, "win");
                m_state = G_WIN;
            end else begin
                nt = m_tries - 1;
`ifdef GUESS_HINT_EN
                hint = (sw > m_target) ? 4'hA : 4'hB;
`else
                hint = 4'h0;
`endif
                expect_at(k + 8, sw, 3'd3, 4'(nt), 1'b0, "miss_pending");
                if (nt == 0) begin
                    expect_at(k + 9, m_target, 3'd2, 4'd0, 1'b1, "lose");
                    m_state = G_LOSE;
                end else begin
                    expect_at(k + 9, {hint, 4'(nt)}, 3'd3, 4'(nt), 1'b0, "again_first");
                    if (span >= 26) begin
                        expect_at(k + 24, {hint, 4'(nt)}, 3'd3, 4'(nt), 1'b0, "again_last");
                        expect_at(k + 25, sw, 3'd3, 4'(nt), 1'b0, "again_to_play");
                    end
                end
                m_tries = nt;
            end
        end else if (m_state == G_WIN || m_state == G_LOSE) begin
            expect_at(k + 9,  m_target, (m_state == G_WIN) ? 3'd1 : 3'd2, 4'(m_tries), 1'b1, "ignored_submit");
            expect_at(k + 20, m_target, (m_state == G_WIN) ? 3'd1 : 3'd2, 4'(m_tries), 1'b1, "ignored_hold");
        end
        repeat (6) @(negedge clock_100Mhz);
        btn_submit = 1'b0;
        repeat (span - 6) @(negedge clock_100Mhz);
    endtask

    task automatic do_both();
        int         k;
        logic [7:0] nt;
        k  = cyc;
        nt = lfsr_adv(m_lfsr, 6);
        sw_guess   = nt;          // would win at once if the submit were checked
        btn_start  = 1'b1;
        btn_submit = 1'b1;
        m_target = nt;
        m_tries  = MAXT;
        m_state  = G_PLAY;
        expect_at(k + 8,  nt, 3'd3, 4'(MAXT), 1'b0, "both_play");
        expect_at(k + 9,  nt, 3'd3, 4'(MAXT), 1'b0, "both_unchecked");
        expect_at(k + 12, nt, 3'd3, 4'(MAXT), 1'b0, "both_stay");
        repeat (6) @(negedge clock_100Mhz);
        btn_start  = 1'b0;
        btn_submit = 1'b0;
        repeat (24) @(negedge clock_100Mhz);
    endtask

    task automatic pulse(input int which, input int n);
        if (which == 0) btn_start = 1'b1; else btn_submit = 1'b1;
        repeat (n) @(negedge clock_100Mhz);
        btn_start  = 1'b0;
        btn_submit = 1'b0;
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nw;
        repeat (2) @(negedge clock_100Mhz);
        expect_at(cyc + 1, 8'h00, 3'd3, 4'(MAXT), 1'b0, "in_reset");
        @(negedge clock_100Mhz);
        expect_at(cyc + 2, 8'h00, 3'd3, 4'(MAXT), 1'b0, "idle_after_reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clock_100Mhz);

        // Short pulses and a 3/1/3 bounce must never be accepted
        sw_guess = 8'h5C;
        pulse(0, 3); repeat (10) @(negedge clock_100Mhz);
        pulse(0, 3); repeat (1) @(negedge clock_100Mhz);
        pulse(0, 3); repeat (10) @(negedge clock_100Mhz);
        pulse(1, 3); repeat (10) @(negedge clock_100Mhz);
        expect_at(cyc + 1, 8'h00, 3'd3, 4'(MAXT), 1'b0, "glitch_idle");
        expect_at(cyc + 6, 8'h00, 3'd3, 4'(MAXT), 1'b0, "glitch_idle_late");
        repeat (8) @(negedge clock_100Mhz);

        // Game A: above, below, then the right number; later submits ignored
        do_start(8'h33);
        do_submit(m_target + 8'd1, 30);
        do_submit(m_target - 8'd1, 30);
        do_submit(m_target, 30);
        do_submit(8'h77, 30);

        // Game B: three misses lose; even the correct value is then ignored
        repeat (7) @(negedge clock_100Mhz);
        do_start(8'hC1);
        do_submit(m_target ^ 8'h0F, 30);
        do_submit(m_target ^ 8'hF0, 30);
        do_submit(m_target ^ 8'hFF, 30);
        do_submit(m_target, 30);

        // Game C: simultaneous start and submit restarts without checking
        do_start(8'h10);
        do_submit(m_target ^ 8'h01, 30);
        do_both();
        do_submit(m_target, 30);

        // Game D: asynchronous reset in the middle of the "again" hold
        do_start(8'h42);
        do_submit(m_target ^ 8'h80, 15);
        @(posedge clock_100Mhz);
        #2;
        expect_at(cyc, 8'h00, 3'd3, 4'(MAXT), 1'b0, "async_reset");
        reset_n = 1'b0;
        m_state = G_IDLE;
        m_tries = MAXT;
        btn_submit = 1'b0;
        repeat (3) @(negedge clock_100Mhz);
        reset_n = 1'b1;
        expect_at(cyc + 3, 8'h00, 3'd3, 4'(MAXT), 1'b0, "post_reset_idle");
        repeat (6) @(negedge clock_100Mhz);
        do_start(8'h99);
        do_submit(m_target, 30);

        // Randomised games
        for (int g = 0; g < 5; g++) begin
            repeat ($urandom_range(1, 25)) @(negedge clock_100Mhz);
            do_start(8'($urandom_range(0, 255)));
            nw = $urandom_range(0, 3);
            for (int i = 0; i < nw; i++) begin
                if (m_state == G_PLAY) do_submit(m_target ^ 8'($urandom_range(1, 255)), 30);
            end
            if (m_state == G_PLAY) do_submit(m_target, 30);
        end

        repeat (30) @(negedge clock_100Mhz);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
